// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI frame capture sequencer.
// Holds the FSM state encoding and the default frame geometry.
package mipi_pkg;

  // Default geometry: 1080 lines of 960 16-bit words.
  localparam int FRAME_ROWS_DEF = 1080;
  localparam int LINE_WORDS_DEF = 960;
  localparam int CNT_W_DEF      = 16;

  // Capture FSM states, kept as plain constants so legacy code can share them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARMED   = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mipi_geom_cnt.sv
// Frame geometry tracking for mipi_frame_ctrl: counts rows (raw_vld rising
// edges while capturing) and words per line, and reports whether the frame
// closing at the current raw_vsync has the expected shape.
// Optional per-line length check: define LINE_LEN_CHECK_EN.
module mipi_geom_cnt import mipi_pkg::*; #(
  parameter int FRAME_ROWS = FRAME_ROWS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic fwd,         // a word is being forwarded this cycle
  input  logic line_end,    // cycle after the last word of a run
  input  logic raw_vld,
  input  logic raw_vsync,
  output logic frame_good   // geometry verdict, meaningful on a closing vsync
);

`ifdef LINE_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  // Constant-false: the length compare below folds away.
  localparam bit LEN_CHECK = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] row_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic             raw_vld_d;
  logic             line_err;
  logic             row_rise;
  logic             len_bad;

  assign row_rise = fwd & ~raw_vld_d;
  assign len_bad  = LEN_CHECK & line_end & (word_cnt != CNT_W'(LINE_WORDS));

  // A line ending on the vsync cycle itself still counts against the frame,
  // and a word arriving together with vsync spoils the closing frame.
  assign frame_good = (row_cnt == CNT_W'(FRAME_ROWS)) & ~line_err & ~len_bad & ~raw_vld;

  // Previous raw_vld, used to find the start of each run.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) raw_vld_d <= 1'b0;
    else         raw_vld_d <= raw_vld;
  end

  // Row/word counters and sticky line error, all restarted at each vsync.
  always_ff @(posedge clk) begin
    if (!resetn || raw_vsync) begin
      row_cnt  <= '0;
      word_cnt <= '0;
      line_err <= 1'b0;
    end else begin
      if (row_rise && row_cnt != CNT_MAX) row_cnt <= row_cnt + CNT_W'(1);
      if (fwd) begin
        if (word_cnt != CNT_MAX) word_cnt <= word_cnt + CNT_W'(1);
      end else if (line_end) begin
        word_cnt <= '0;
      end
      if (len_bad) line_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mipi_frame_ctrl.sv
// Frame capture sequencer between the MIPI RAW unpacker and frame storage.
// Arms on cfg_start, aligns to the next raw_vsync, forwards whole frames
// with sof/eol/eof markers, grades each frame's geometry and stops after one
// frame (single mode) or at the frame boundary following cfg_stop.
// Optional per-line length check: define LINE_LEN_CHECK_EN.
module mipi_frame_ctrl import mipi_pkg::*; #(
  parameter int FRAME_ROWS = FRAME_ROWS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_single,
  input  logic             raw_vld,
  input  logic [15:0]      raw_data,
  input  logic             raw_vsync,
  output logic             out_vld,
  output logic [15:0]      out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt
);

  state_t state;
  logic   single_r;
  logic   stop_pend;
  logic   sof_pend;
  logic   fwd;
  logic   close;
  logic   frame_good;

  // A word coinciding with vsync is never forwarded.
  assign fwd     = (state == ST_CAPTURE) & raw_vld & ~raw_vsync;
  assign close   = (state == ST_CAPTURE) & raw_vsync;
  assign busy    = (state != ST_IDLE);
  assign out_eol = out_vld & ~raw_vld;

  mipi_geom_cnt #(
    .FRAME_ROWS (FRAME_ROWS),
    .LINE_WORDS (LINE_WORDS),
    .CNT_W      (CNT_W)
  ) u_geom (
    .clk        (clk),
    .resetn     (resetn),
    .fwd        (fwd),
    .line_end   (out_eol),
    .raw_vld    (raw_vld),
    .raw_vsync  (raw_vsync),
    .frame_good (frame_good)
  );

  // Capture FSM: IDLE -> ARMED -> CAPTURE, leaving at a frame boundary.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      single_r  <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Start wins over a same-cycle stop; stop alone is ignored here.
          if (cfg_start) begin
            state     <= ST_ARMED;
            single_r  <= cfg_single;
            stop_pend <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (cfg_stop)       state <= ST_IDLE;
          else if (raw_vsync) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (raw_vsync) begin
            if (single_r || stop_pend || cfg_stop) begin
              state     <= ST_IDLE;
              stop_pend <= 1'b0;
            end
          end else if (cfg_stop) begin
            stop_pend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered datapath, frame markers and frame statistics.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      sof_pend   <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      out_vld    <= fwd;
      out_data   <= fwd ? raw_data : 16'h0000;
      out_sof    <= fwd & sof_pend;
      out_eof    <= close;
      frame_done <= close & frame_good;
      frame_err  <= close & ~frame_good;
      // Every vsync opens a potential frame; the first forwarded word takes sof.
      if (raw_vsync) sof_pend <= 1'b1;
      else if (fwd)  sof_pend <= 1'b0;
      if (close && frame_good)  frame_cnt <= frame_cnt + CNT_W'(1);
      if (close && !frame_good) err_cnt   <= sat_inc8(err_cnt);
    end
  end

endmodule
